// File: rtl/uart_tx_frame_scheduler.sv
// Round-robin scheduler that serialises whole frames from NREQ producers onto one UART TX word stream.
// Define UART_TX_SCHED_HDR_EN to prefix each frame with a header word HDR_BASE + requester index.
module uart_tx_frame_scheduler #(
   parameter int unsigned      NREQ     = 4,
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] HDR_BASE = 8'hA0
) (
   input  logic                                     clk,
   input  logic                                     arstn,
   input  logic [NREQ-1:0]                          req_valid,
   output logic [NREQ-1:0]                          req_ready,
   input  logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0]    req_data,
   output logic                                     tx_valid,
   input  logic                                     tx_ready,
   output logic [WIDTH-1:0]                         tx_data,
   output logic [$clog2(NREQ)-1:0]                  tx_id,
   output logic                                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef UART_TX_SCHED_HDR_EN
   localparam logic [1:0] ST_HDR  = 2'd1;
`endif
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]                       state;
   logic [IDW-1:0]                   rr_ptr;
   logic [CW-1:0]                    cnt;
   logic [DEPTH-1:0][WIDTH-1:0]      frame_q;
   logic [IDW-1:0]                   grant;
   logic                             found;
   logic                             accept;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin : arb
      int unsigned    idx;
      logic [IDW-1:0] idx_w;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      idx_w = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = IDW'(idx);
         if (!found && req_valid[idx_w]) begin
            found = 1'b1;
            grant = idx_w;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && found) req_ready[grant] = 1'b1;
   end

   assign tx_valid = (state != ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      tx_data = '0;
      case (state)
`ifdef UART_TX_SCHED_HDR_EN
         ST_HDR:  tx_data = HDR_BASE + WIDTH'(tx_id);
`endif
         ST_DATA: tx_data = frame_q[cnt];
         default: tx_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         cnt     <= '0;
         tx_id   <= '0;
         frame_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  frame_q <= req_data[grant];
                  tx_id   <= grant;
                  rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
`ifdef UART_TX_SCHED_HDR_EN
                  state   <= ST_HDR;
`else
                  state   <= ST_DATA;
`endif
               end
            end
`ifdef UART_TX_SCHED_HDR_EN
            ST_HDR: begin
               if (accept) state <= ST_DATA;
            end
`endif
            ST_DATA: begin
               if (accept) begin
                  if (cnt == CW'(DEPTH - 1)) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Directed self-checking bench for uart_tx_frame_scheduler; works with or without UART_TX_SCHED_HDR_EN.
module tb_uart_tx_frame_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef UART_TX_SCHED_HDR_EN
   localparam int HLEN = 1;
`else
   localparam int HLEN = 0;
`endif

   logic                                  clk = 1'b0;
   logic                                  arstn;
   logic [NREQ-1:0]                       req_valid;
   logic [NREQ-1:0]                       req_ready;
   logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0] req_data;
   logic                                  tx_valid;
   logic                                  tx_ready;
   logic [WIDTH-1:0]                      tx_data;
   logic [1:0]                            tx_id;
   logic                                  busy;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_frame_scheduler #(
      .NREQ     (NREQ),
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .HDR_BASE (8'hA0)
   ) dut (
      .clk       (clk),
      .arstn     (arstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_id     (tx_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx_valid"}, 32'(tx_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
   endtask

   // Entered just after a rising edge with the DUT in IDLE and req_valid already driven.
   task automatic run_frame(input int gid, input bit stall, input bit drop_valid, input bit mutate);
      logic [WIDTH-1:0] exp_w [DEPTH+1];
      int nw, k, cyc;
      bit acc;
      nw = DEPTH + HLEN;
      for (int i = 0; i < nw; i++) begin
         if (HLEN == 1 && i == 0) exp_w[i] = 8'hA0 + 8'(gid);
         else                     exp_w[i] = req_data[gid][i-HLEN];
      end
      @(negedge clk);
      check("idle_tx_valid", 32'(tx_valid), 0);
      check("idle_busy", 32'(busy), 0);
      check("grant", 32'(req_ready), 32'(1) << gid);
      @(posedge clk); #1;
      if (drop_valid) req_valid = '0;
      if (mutate) req_data[gid] = ~req_data[gid];
      k = 0;
      cyc = 0;
      while (k < nw) begin
         tx_ready = stall ? (cyc % 3 == 0) : 1'b1;
         @(negedge clk);
         check("tx_valid", 32'(tx_valid), 1);
         check("tx_data", 32'(tx_data), 32'(exp_w[k]));
         check("tx_id", 32'(tx_id), 32'(gid));
         check("busy_req_ready", 32'(req_ready), 0);
         check("busy", 32'(busy), 1);
         acc = tx_ready;
         @(posedge clk); #1;
         if (acc) k++;
         cyc++;
      end
      tx_ready = 1'b1;
   endtask

   initial begin
      arstn     = 1'b0;
      req_valid = '0;
      tx_ready  = 1'b1;
      for (int i = 0; i < NREQ; i++)
         for (int w = 0; w < DEPTH; w++)
            req_data[i][w] = 8'(16 * i + w + 1);
      req_data[2][0] = 8'h11;
      req_data[2][1] = 8'h22;
      req_data[2][2] = 8'h33;
      req_data[2][3] = 8'h44;

      // Reset and quiet idle
      #23;
      arstn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_idle("reset");
         check("reset_tx_data", 32'(tx_data), 0);
         check("reset_tx_id", 32'(tx_id), 0);
      end
      @(posedge clk); #1;

      // Single requester 2
      req_valid = 4'b0100;
      run_frame(2, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_idle("hold");
      end
      @(posedge clk); #1;

      // rr_ptr=3: wrap to 0, then 1
      req_valid = 4'b0011;
      run_frame(0, 1'b0, 1'b0, 1'b0);
      run_frame(1, 1'b0, 1'b1, 1'b0);

      // All valid: rr_ptr=2 gives 2,3,0,1; requester 3's inputs change after capture
      req_valid = 4'b1111;
      run_frame(2, 1'b0, 1'b0, 1'b0);
      run_frame(3, 1'b0, 1'b0, 1'b1);
      run_frame(0, 1'b0, 1'b0, 1'b0);
      run_frame(1, 1'b0, 1'b1, 1'b0);

      // Backpressure 1,0,0,1,... with rr_ptr=2, only requester 1 valid
      req_valid = 4'b0010;
      run_frame(1, 1'b1, 1'b1, 1'b0);

      // Reset after two accepted words
      req_valid = 4'b0001;
      @(negedge clk);
      check("mid_grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("mid_tx_valid", 32'(tx_valid), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      arstn = 1'b0;
      #1;
      check("async_tx_valid", 32'(tx_valid), 0);
      check("async_busy", 32'(busy), 0);
      check("async_tx_data", 32'(tx_data), 0);
      check("async_tx_id", 32'(tx_id), 0);
      #10;
      arstn = 1'b1;
      @(posedge clk); #1;
      req_valid = 4'b1000;
      run_frame(3, 1'b0, 1'b1, 1'b0);

      @(negedge clk);
      check_idle("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
